fig_rom_arbiter: RTL and testbench

FIG_ROM_ARBITER -- requirements
Module: fig_rom_arbiter

---
 rtl/fig_rom_arbiter_if.sv | 37 +++
 rtl/fig_rom_arbiter.sv | 116 +++++++++++
 tb/tb_fig_rom_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/fig_rom_arbiter_if.sv
// Requester-side and ROM-side signals of the two-port ROM arbiter.
// slave is the arbiter's view; master is the view of whoever drives the
// requests and models the ROM.
interface fig_rom_arbiter_if #(
   parameter int c_ADDR_WIDTH = 10,
   parameter int c_DATA_WIDTH = 32
);
   // requester side
   logic                    req0;
   logic                    req1;
   logic [c_ADDR_WIDTH-1:0] addr0;
   logic [c_ADDR_WIDTH-1:0] addr1;
   logic                    gnt0;
   logic                    gnt1;
   logic                    rvalid0;
   logic                    rvalid1;
   logic [c_DATA_WIDTH-1:0] rdata;
   logic                    busy;
   // ROM side
   logic [c_ADDR_WIDTH-1:0] rom_addr;
   logic                    rom_clk_en;
   logic                    rom_addr_strobe;
   logic                    rom_rd_oce;
   logic [c_DATA_WIDTH-1:0] rom_rd_data;

   modport slave (
      input  req0, req1, addr0, addr1, rom_rd_data,
      output gnt0, gnt1, rvalid0, rvalid1, rdata, busy,
             rom_addr, rom_clk_en, rom_addr_strobe, rom_rd_oce
   );

   modport master (
      output req0, req1, addr0, addr1, rom_rd_data,
      input  gnt0, gnt1, rvalid0, rvalid1, rdata, busy,
             rom_addr, rom_clk_en, rom_addr_strobe, rom_rd_oce
   );
endinterface

// File: rtl/fig_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous ROM between two requesters.
// Grants are combinational, one read is accepted per cycle, and a
// valid/ID shift register as deep as the ROM latency routes each returning
// word to the requester that issued it.
module fig_rom_arbiter #(
   parameter int c_ADDR_WIDTH = 10,
   parameter int c_DATA_WIDTH = 32,
   parameter int c_RD_LATENCY = 1   // 1: no ROM output register, 2: with it
) (
   input  logic             clk,
   input  logic             rst,
   fig_rom_arbiter_if.slave bus
);

   logic                    gnt0;
   logic                    gnt1;
   logic                    any_gnt;
   logic                    rvalid0;
   logic                    rvalid1;
   logic                    last_q;      // ID granted most recently
   logic                    last_d;
   logic [c_ADDR_WIDTH-1:0] rom_addr_q;
   logic [c_ADDR_WIDTH-1:0] rom_addr_d;
   logic [c_RD_LATENCY-1:0] vld_q;
   logic [c_RD_LATENCY-1:0] vld_d;
   logic [c_RD_LATENCY-1:0] id_q;        // 0: requester 0, 1: requester 1
   logic [c_RD_LATENCY-1:0] id_d;
   logic                    busy_q;
   logic                    busy_d;
   logic [c_DATA_WIDTH-1:0] rdata_q;
   logic [c_DATA_WIDTH-1:0] rdata_d;

   // Grant: a lone request wins at once; on contention the requester not
   // granted last wins. Nothing is granted while reset is held.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!rst) begin
         gnt0 = bus.req0 & (~bus.req1 | last_q);
         gnt1 = bus.req1 & (~bus.req0 | ~last_q);
      end
   end

   assign any_gnt = gnt0 | gnt1;
   assign rvalid0 = vld_q[c_RD_LATENCY-1] & ~id_q[c_RD_LATENCY-1];
   assign rvalid1 = vld_q[c_RD_LATENCY-1] &  id_q[c_RD_LATENCY-1];

   // Next state: pointer, held ROM address, in-flight pipeline, read data.
   always_comb begin
      last_d     = last_q;
      rom_addr_d = rom_addr_q;
      if (gnt0) begin
         last_d     = 1'b0;
         rom_addr_d = bus.addr0;
      end else if (gnt1) begin
         last_d     = 1'b1;
         rom_addr_d = bus.addr1;
      end

      vld_d[0] = any_gnt;
      id_d[0]  = gnt1;
      for (int i = 1; i < c_RD_LATENCY; i++) begin
         vld_d[i] = vld_q[i-1];
         id_d[i]  = id_q[i-1];
      end
      busy_d = |vld_d;

      rdata_d = rdata_q;
      if (rvalid0 || rvalid1) begin
         rdata_d = bus.rom_rd_data;
      end
   end

   // State registers; reset drops every in-flight read and favours requester 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the in-flight pipeline is reset too, so reads accepted before reset can never raise rvalid afterwards.
         last_q     <= 1'b1;
         rom_addr_q <= '0;
         vld_q      <= '0;
         id_q       <= '0;
         busy_q     <= 1'b0;
         rdata_q    <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         last_q     <= last_d;
         rom_addr_q <= rom_addr_d;
         vld_q      <= vld_d;
         id_q       <= id_d;
         busy_q     <= busy_d;
         rdata_q    <= rdata_d;
      end
   end

   assign bus.gnt0            = gnt0;
   assign bus.gnt1            = gnt1;
   assign bus.rvalid0         = rvalid0;
   assign bus.rvalid1         = rvalid1;
   assign bus.busy            = busy_q;
   assign bus.rom_addr        = rom_addr_d;
   assign bus.rom_addr_strobe = any_gnt;
   assign bus.rom_clk_en      = any_gnt | busy_q;
   // Returning data passes straight through; the register keeps it afterwards.
   assign bus.rdata           = (rvalid0 || rvalid1) ? bus.rom_rd_data : rdata_q;

   // The ROM output register is clocked the cycle before data is due.
   generate
      if (c_RD_LATENCY == 2) begin : g_oce
         assign bus.rom_rd_oce = vld_q[0];
      end else begin : g_no_oce
         assign bus.rom_rd_oce = 1'b0;
      end
   endgenerate

endmodule

// File: tb/tb_fig_rom_arbiter.sv
// Directed bench for fig_rom_arbiter: one instance at read latency 1 and
// one at latency 2, each with a behavioural ROM holding {16'hC0DE, addr}.
module tb_fig_rom_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_total = 0;
   int   n_bad   = 0;

   always #5 clk = ~clk;

   fig_rom_arbiter_if #(.c_ADDR_WIDTH(10), .c_DATA_WIDTH(32)) bus1 ();
   fig_rom_arbiter_if #(.c_ADDR_WIDTH(10), .c_DATA_WIDTH(32)) bus2 ();

   fig_rom_arbiter #(.c_ADDR_WIDTH(10), .c_DATA_WIDTH(32), .c_RD_LATENCY(1)) u_dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   fig_rom_arbiter #(.c_ADDR_WIDTH(10), .c_DATA_WIDTH(32), .c_RD_LATENCY(2)) u_dut2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2)
   );

   function automatic logic [31:0] rom_word(input logic [9:0] a);
      return {16'hC0DE, 6'd0, a};
   endfunction

   // Latency-1 ROM: registered read.
   always @(posedge clk) begin
      if (bus1.rom_clk_en && bus1.rom_addr_strobe) bus1.rom_rd_data <= rom_word(bus1.rom_addr);
   end

   // Latency-2 ROM: registered read plus output register gated by oce.
   logic [31:0] ram2_q;
   always @(posedge clk) begin
      if (bus2.rom_clk_en && bus2.rom_addr_strobe) ram2_q <= rom_word(bus2.rom_addr);
      if (bus2.rom_clk_en && bus2.rom_rd_oce)      bus2.rom_rd_data <= ram2_q;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   initial begin
      bus1.req0 = 1'b0; bus1.req1 = 1'b0; bus1.addr0 = '0; bus1.addr1 = '0;
      bus2.req0 = 1'b0; bus2.req1 = 1'b0; bus2.addr0 = '0; bus2.addr1 = '0;

      // ---------------- reset state (request held during reset) ----------
      bus1.req0 = 1'b1;
      bus2.req1 = 1'b1;
      cyc(); cyc(); mid();
      check("rst gnt0",     bus1.gnt0, 0);
      check("rst gnt1",     bus2.gnt1, 0);
      check("rst rvalid0",  bus1.rvalid0, 0);
      check("rst busy",     bus1.busy, 0);
      check("rst strobe",   bus1.rom_addr_strobe, 0);
      check("rst clk_en",   bus1.rom_clk_en, 0);
      check("rst oce",      bus2.rom_rd_oce, 0);
      check("rst rdata",    bus1.rdata, 0);
      check("rst rom_addr", bus1.rom_addr, 0);
      cyc();
      rst = 1'b0;
      bus2.req1 = 1'b0;

      // ---------------- contention right after reset: 0,1,0,1 ------------
      for (int k = 0; k < 6; k++) begin
         if (k < 4) begin
            bus1.req0 = 1'b1; bus1.addr0 = 10'(16 + k);
            bus1.req1 = 1'b1; bus1.addr1 = 10'(32 + k);
         end else begin
            bus1.req0 = 1'b0; bus1.req1 = 1'b0;
         end
         mid();
         check("rr gnt0", bus1.gnt0, (k < 4) && (k % 2 == 0));
         check("rr gnt1", bus1.gnt1, (k < 4) && (k % 2 == 1));
         if (k < 4)
            check("rr rom_addr", bus1.rom_addr, (k % 2 == 0) ? 10'(16 + k) : 10'(32 + k));
         if (k >= 1 && k <= 4) begin
            check("rr rvalid0", bus1.rvalid0, (k - 1) % 2 == 0);
            check("rr rvalid1", bus1.rvalid1, (k - 1) % 2 == 1);
            check("rr rdata", bus1.rdata,
                  ((k - 1) % 2 == 0) ? rom_word(10'(16 + k - 1)) : rom_word(10'(32 + k - 1)));
         end
         if (k == 5) begin
            check("rr idle busy",   bus1.busy, 0);
            check("rr idle clk_en", bus1.rom_clk_en, 0);
            check("rr rdata hold",  bus1.rdata, rom_word(10'h023));
         end
         cyc();
      end

      // ---------------- lone read on both latencies -----------------------
      bus1.req0 = 1'b1; bus1.addr0 = 10'h005;
      bus2.req0 = 1'b1; bus2.addr0 = 10'h005;
      mid();
      check("lone1 gnt0",     bus1.gnt0, 1);
      check("lone1 strobe",   bus1.rom_addr_strobe, 1);
      check("lone1 rom_addr", bus1.rom_addr, 10'h005);
      check("lone1 clk_en",   bus1.rom_clk_en, 1);
      check("lone2 gnt0",     bus2.gnt0, 1);
      cyc();
      bus1.req0 = 1'b0; bus2.req0 = 1'b0;
      mid();
      check("lone1 rvalid0", bus1.rvalid0, 1);
      check("lone1 rdata",   bus1.rdata, rom_word(10'h005));
      check("lone1 busy",    bus1.busy, 1);
      check("lone1 oce",     bus1.rom_rd_oce, 0);
      check("lone1 strobe off", bus1.rom_addr_strobe, 0);
      check("lone2 oce",     bus2.rom_rd_oce, 1);
      check("lone2 early rvalid0", bus2.rvalid0, 0);
      check("lone2 clk_en",  bus2.rom_clk_en, 1);
      cyc();
      mid();
      check("lone1 rvalid0 once", bus1.rvalid0, 0);
      check("lone1 busy off",     bus1.busy, 0);
      check("lone1 rdata hold",   bus1.rdata, rom_word(10'h005));
      check("lone2 rvalid0",      bus2.rvalid0, 1);
      check("lone2 rdata",        bus2.rdata, rom_word(10'h005));
      check("lone2 oce off",      bus2.rom_rd_oce, 0);
      cyc();
      mid();
      check("lone2 rvalid0 once", bus2.rvalid0, 0);
      check("lone2 clk_en off",   bus2.rom_clk_en, 0);
      cyc();

      // ---------------- back-to-back reads on requester 1 -----------------
      for (int k = 0; k < 10; k++) begin
         if (k < 8) begin
            bus1.req1 = 1'b1; bus1.addr1 = 10'(k);
         end else begin
            bus1.req1 = 1'b0;
         end
         mid();
         check("b2b gnt1",    bus1.gnt1, k < 8);
         check("b2b gnt0",    bus1.gnt0, 0);
         check("b2b rvalid1", bus1.rvalid1, (k >= 1) && (k <= 8));
         check("b2b busy",    bus1.busy, (k >= 1) && (k <= 8));
         if (k >= 1 && k <= 8)
            check("b2b rdata", bus1.rdata, rom_word(10'(k - 1)));
         cyc();
      end

      // ---------------- withdrawn request keeps the pointer ----------------
      bus1.req0 = 1'b1; bus1.addr0 = 10'h040;
      bus1.req1 = 1'b1; bus1.addr1 = 10'h041;
      mid();
      check("wd gnt0", bus1.gnt0, 1);
      check("wd gnt1", bus1.gnt1, 0);
      cyc();
      bus1.req0 = 1'b0; bus1.req1 = 1'b0;
      mid();
      check("wd dropped gnt1", bus1.gnt1, 0);
      check("wd rvalid0",      bus1.rvalid0, 1);
      cyc();
      bus1.req0 = 1'b1; bus1.req1 = 1'b1;
      mid();
      check("wd next gnt1",     bus1.gnt1, 1);
      check("wd next gnt0",     bus1.gnt0, 0);
      check("wd next rom_addr", bus1.rom_addr, 10'h041);
      cyc();
      bus1.req0 = 1'b0; bus1.req1 = 1'b0;
      mid();
      check("wd rvalid1", bus1.rvalid1, 1);
      check("wd rdata",   bus1.rdata, rom_word(10'h041));
      cyc();

      // ---------------- reset mid-flight, latency 2 ------------------------
      bus2.req0 = 1'b1; bus2.addr0 = 10'h033;
      mid();
      check("mf gnt0", bus2.gnt0, 1);
      cyc();
      rst = 1'b1;
      mid();
      check("mf rst gnt0",     bus2.gnt0, 0);
      check("mf rst rvalid0",  bus2.rvalid0, 0);
      check("mf rst busy",     bus2.busy, 0);
      check("mf rst strobe",   bus2.rom_addr_strobe, 0);
      check("mf rst clk_en",   bus2.rom_clk_en, 0);
      check("mf rst oce",      bus2.rom_rd_oce, 0);
      check("mf rst rdata",    bus2.rdata, 0);
      check("mf rst rom_addr", bus2.rom_addr, 0);
      check("mf rst rdata1",   bus1.rdata, 0);
      cyc();
      rst = 1'b0;
      bus2.addr0 = 10'h044;
      mid();
      check("mf no stale rvalid0", bus2.rvalid0, 0);
      check("mf resume gnt0",      bus2.gnt0, 1);
      check("mf resume rom_addr",  bus2.rom_addr, 10'h044);
      cyc();
      bus2.req0 = 1'b0;
      mid();
      check("mf new oce",     bus2.rom_rd_oce, 1);
      check("mf new rvalid0 early", bus2.rvalid0, 0);
      cyc();
      mid();
      check("mf new rvalid0", bus2.rvalid0, 1);
      check("mf new rdata",   bus2.rdata, rom_word(10'h044));
      cyc();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   // Mutual exclusion of the grants, checked every cycle after reset.
   always @(negedge clk) begin
      if (!rst && ((bus1.gnt0 && bus1.gnt1) || (bus2.gnt0 && bus2.gnt1)))
         check("gnt exclusive", 1, 0);
   end

endmodule
